uart_fifo_tx: RTL and testbench

//  Read-side consumer of the async FIFO: pops bytes from the FIFO read port and serialises them as UART frames.

---
 rtl/uart_fifo_tx.sv | 147 ++++++++++++++
 tb/tb_uart_fifo_tx.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_tx.sv
// uart_fifo_tx: pops bytes from an async FIFO read port and sends them as UART frames.
// Optional even parity bit between data and stop when UART_TX_PARITY_EN is defined.
module uart_fifo_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                  rd_clk,
    input  logic                  rd_reset,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    input  logic                  tx_enable,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE, FETCH, LOAD, START, DATA, PARITY, STOP
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, FETCH, LOAD, START, DATA, STOP
    } state_t;
`endif

    state_t                  state;
    logic [CW-1:0]           baud_cnt;
    logic [BW-1:0]           bit_idx;
    logic [DATA_WIDTH-1:0]   shift_reg;
`ifdef UART_TX_PARITY_EN
    logic                    parity_bit;
`endif

    logic baud_last;
    logic bit_last;

    assign baud_last = (baud_cnt == BAUD_LAST);
    assign bit_last  = (bit_idx == BIT_LAST);

    // Frame sequencer: one pop per frame, registered line and status outputs
    always_ff @(posedge rd_clk or posedge rd_reset) begin
        if (rd_reset) begin
            state      <= IDLE;
            tx         <= 1'b1;
            fifo_rd_en <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            frame_done <= 1'b0;
            fifo_rd_en <= 1'b0;
            unique case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (tx_enable && !fifo_empty) begin
                        fifo_rd_en <= 1'b1;
                        busy       <= 1'b1;
                        state      <= FETCH;
                    end
                end
                FETCH: begin
                    // FIFO output becomes valid during LOAD
                    state <= LOAD;
                end
                LOAD: begin
                    shift_reg <= fifo_data;
`ifdef UART_TX_PARITY_EN
                    parity_bit <= ^fifo_data;
`endif
                    tx       <= 1'b0;
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    state    <= START;
                end
                START: begin
                    if (baud_last) begin
                        baud_cnt  <= '0;
                        tx        <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                        state     <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (bit_last) begin
`ifdef UART_TX_PARITY_EN
                            tx    <= parity_bit;
                            state <= PARITY;
`else
                            tx    <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            bit_idx   <= bit_idx + 1'b1;
                            tx        <= shift_reg[0];
                            shift_reg <= shift_reg >> 1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        tx       <= 1'b1;
                        state    <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (baud_last) begin
                        baud_cnt   <= '0;
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_fifo_tx.sv
// tb_uart_fifo_tx: FIFO model with 1-cycle read latency, UART line decoder
// and expected-byte queue for uart_fifo_tx.
module tb_uart_fifo_tx;

    localparam int DW  = 8;
    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = DW + 3;
`else
    localparam int NBITS = DW + 2;
`endif
    localparam int FLEN = NBITS * CPB;

    typedef struct {
        logic [7:0] data;
        logic       par;
    } vec_t;

    logic       rd_clk     = 1'b0;
    logic       rd_reset   = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_data  = 8'h00;
    logic       tx_enable  = 1'b0;
    logic       fifo_rd_en;
    logic       tx;
    logic       busy;
    logic       frame_done;

    logic       push_valid = 1'b0;
    logic [7:0] push_byte  = 8'h00;
    logic [7:0] fq[$];

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    vec_t exp_q[$];

    bit         m_act = 0;
    int         m_start = 0;
    int         m_off = 0;
    logic [7:0] m_byte = 8'h00;
`ifdef UART_TX_PARITY_EN
    logic       m_par = 1'b0;
`endif
    int         prev_start = -1;
    bit         gap_chk = 0;
    int         rd_cnt = 0;
    logic       prev_en = 1'b0;

    uart_fifo_tx #(
        .DATA_WIDTH  (DW),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .rd_clk    (rd_clk),
        .rd_reset  (rd_reset),
        .fifo_empty(fifo_empty),
        .fifo_data (fifo_data),
        .fifo_rd_en(fifo_rd_en),
        .tx_enable (tx_enable),
        .tx        (tx),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 rd_clk = ~rd_clk;

    // Behavioural FIFO: push first, pop data visible one cycle after rd_en
    always @(posedge rd_clk) begin : fifo_model
        logic [7:0] t;
        if (push_valid) fq.push_back(push_byte);
        if (fifo_rd_en && fq.size() != 0) begin
            t = fq.pop_front();
            fifo_data <= t;
        end
        fifo_empty <= (fq.size() == 0);
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Line decoder and handshake watcher, run once per negedge
    task automatic mon();
        int   b;
        vec_t e;
        if (rd_reset) begin
            m_act   = 0;
            prev_en = 1'b0;
            return;
        end
        if (fifo_rd_en) begin
            rd_cnt++;
            chk("rd_en_while_empty", 32'(fifo_empty), 0);
            chk("rd_en_width", 32'(prev_en), 0);
        end
        prev_en = fifo_rd_en;
        if (frame_done) chk("frame_done_time", cyc - m_start, FLEN);
        if (!m_act) begin
            if (tx === 1'b0) begin
                m_act = 1;
                m_off = 0;
                if (gap_chk && prev_start >= 0)
                    chk("frame_gap", cyc - prev_start, FLEN + 3);
                prev_start = cyc;
                m_start    = cyc;
            end
        end else begin
            m_off++;
            if (m_off % CPB == CPB / 2) begin
                b = m_off / CPB;
                if (b == 0) begin
                    chk("start_bit", 32'(tx), 0);
                end else if (b <= DW) begin
                    m_byte[b-1] = tx;
                end else if (b == NBITS - 1) begin
                    chk("stop_bit", 32'(tx), 1);
                    chk("busy_in_frame", 32'(busy), 1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame: got %0h expected none",
                                 m_byte);
                    end else begin
                        e = exp_q.pop_front();
                        chk("frame_data", 32'(m_byte), 32'(e.data));
`ifdef UART_TX_PARITY_EN
                        chk("parity_bit", 32'(m_par), 32'(e.par));
`endif
                    end
                    m_act = 0;
                end else begin
`ifdef UART_TX_PARITY_EN
                    m_par = tx;
`endif
                end
            end
        end
    endtask

    task automatic step();
        @(negedge rd_clk);
        cyc++;
        mon();
    endtask

    task automatic push(input logic [7:0] d, input logic p);
        vec_t e;
        e.data = d;
        e.par  = p;
        exp_q.push_back(e);
        push_valid = 1'b1;
        push_byte  = d;
        step();
        push_valid = 1'b0;
    endtask

    task automatic drain(input int max);
        int n = 0;
        while ((exp_q.size() != 0 || busy || m_act || fq.size() != 0)
               && n < max) begin
            step();
            n++;
        end
        checks++;
        if (n >= max) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0",
                     exp_q.size());
        end
        step();
        step();
    endtask

    task automatic wait_start(input int max);
        int n = 0;
        while (!m_act && n < max) begin
            step();
            n++;
        end
        checks++;
        if (!m_act) begin
            errors++;
            $display("FAIL start_timeout: got no start bit expected one");
        end
    endtask

    vec_t tbl[5];

    initial begin
        int rd0;
        int viol;
        logic [7:0] v;

        tbl[0] = '{data: 8'h55, par: 1'b0};
        tbl[1] = '{data: 8'h01, par: 1'b1};
        tbl[2] = '{data: 8'h80, par: 1'b1};
        tbl[3] = '{data: 8'h0B, par: 1'b1};
        tbl[4] = '{data: 8'hEF, par: 1'b1};

        // reset state
        #2 rd_reset = 1'b1;
        #1;
        chk("rst_tx", 32'(tx), 1);
        chk("rst_rd_en", 32'(fifo_rd_en), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        step();
        step();
        tx_enable = 1'b1;
        rd_reset  = 1'b0;

        // empty FIFO, enabled, 100 cycles of quiet line
        viol = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (tx !== 1'b1 || fifo_rd_en !== 1'b0 || busy !== 1'b0)
                viol++;
        end
        chk("idle_quiet", viol, 0);

        // single frames from the vector table
        for (int i = 0; i < 5; i++) begin
            rd0 = rd_cnt;
            push(tbl[i].data, tbl[i].par);
            drain(200);
            chk("single_pop", rd_cnt - rd0, 1);
        end

        // back-to-back frames with 3-cycle gap
        rd0        = rd_cnt;
        prev_start = -1;
        gap_chk    = 1;
        push(8'h00, 1'b0);
        push(8'hFF, 1'b0);
        push(8'hA5, 1'b0);
        drain(400);
        gap_chk = 0;
        chk("burst3_pops", rd_cnt - rd0, 3);

        // reset 10 cycles into DATA abandons the frame
        rd0 = rd_cnt;
        push(8'h3C, 1'b0);
        push(8'h99, 1'b0);
        wait_start(50);
        while (cyc < m_start + CPB + 10) step();
        rd_reset = 1'b1;
        #1;
        chk("midrst_tx", 32'(tx), 1);
        chk("midrst_busy", 32'(busy), 0);
        void'(exp_q.pop_front());
        viol = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (fifo_rd_en !== 1'b0) viol++;
        end
        chk("midrst_no_rd_en", viol, 0);
        rd_reset = 1'b0;
        drain(200);
        chk("midrst_pops", rd_cnt - rd0, 2);

        // tx_enable dropped mid-frame: current frame finishes, no fetch
        rd0 = rd_cnt;
        push(8'h81, 1'b0);
        push(8'h7E, 1'b0);
        wait_start(50);
        tx_enable = 1'b0;
        for (int i = 0; i < 100; i++) step();
        chk("dis_pops", rd_cnt - rd0, 1);
        chk("dis_fifo_left", fq.size(), 1);
        chk("dis_exp_left", exp_q.size(), 1);
        chk("dis_busy", 32'(busy), 0);
        tx_enable = 1'b1;
        drain(200);
        chk("reen_pops", rd_cnt - rd0, 2);

        // 16-deep fill, drained in order
        tx_enable = 1'b0;
        for (int i = 0; i < 16; i++) begin
            v = 8'(i);
            push(v, ^v);
        end
        rd0        = rd_cnt;
        prev_start = -1;
        gap_chk    = 1;
        tx_enable  = 1'b1;
        drain(16 * (FLEN + 10));
        gap_chk = 0;
        chk("fill16_pops", rd_cnt - rd0, 16);
        chk("fill16_empty", 32'(fifo_empty), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
